node_calculator: RTL and testbench
==================================

Name: node_calculator

Overview:
- Single-neuron compute node: streams one (value, weight) pair per clock and multiply-accumulates them in signed Q12.4 fixed point.
- After N_INPUTS pairs it applies saturation and ReLU, then registers the result on out.
- Sits between the layer's input/weight sequencer and the next layer's input bus.
- Runs free: a new pair is consumed on every clock edge while reset is released.

Parameters:
- DATA_W, 16, width of value/weight/out (signed two's complement).
- FRAC_W, 4, fractional bits (Q12.4, so 1.0 = 16 = 0x0010).
- N_INPUTS, 10, pairs per output frame.
- ACC_W, 32, internal accumulator width (must be ≥ 2*DATA_W−FRAC_W+clog2(N_INPUTS)).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- value  in  DATA_W  signed Q12.4 activation sample.
- weight  in  DATA_W  signed Q12.4 weight sample.
- out  out  DATA_W  registered node result, Q12.4, always ≥ 0.
- out_valid  out  1  one-cycle pulse, high in the cycle after a new out is loaded.

Behaviour:
- Reset (reset=0, asynchronous): accumulator = 0, sample counter = 0, out = 0, out_valid = 0. All registers stay cleared while reset is low.
- Reset released mid-frame: the partial accumulation is discarded. The first edge after release is sample 0 of a new frame.
- Per rising edge with reset=1:
  - prod = signed(value) * signed(weight), full 2*DATA_W bits.
  - Arithmetic right shift by FRAC_W (truncate toward −inf).
  - Sign-extend to ACC_W.
  - sum = acc + prod_scaled.
- Counter < N_INPUTS−1: acc <= sum, counter <= counter+1, out_valid <= 0, out holds.
- Counter == N_INPUTS−1 (frame end):
  - out <= relu(sat(sum)).
  - out_valid <= 1.
  - acc <= 0, counter <= 0; the next edge starts a new frame.
- sat: clamp the ACC_W-bit sum to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- relu: negative results become 0. Resulting range is 0 … 0x7FFF.
- Latency: out reflects the frame containing pair k and is updated on the same edge that samples the last pair (pair N_INPUTS−1). It holds until the next frame end.
- Accumulator cannot overflow internally given the ACC_W rule; saturation applies only at the output.
- No handshake; the upstream block must present a valid pair on every cycle after reset release. Zero pairs contribute nothing.

Decomposition:
- Shared package node_calc_pkg:
  - DATA_W, FRAC_W, ACC_W defaults.
  - Q12.4 typedef (signed [15:0]).
  - Constants Q_ONE = 16, Q_MAX = 0x7FFF, Q_MIN = 0x8000.
- One sub-module, node_mac: a combinational multiply + shift + sign-extend producing prod_scaled.
- Counter, accumulator, sat/relu and output registers stay in node_calculator.

Test Plan:
- Reset hold: reset=0 with random value/weight toggling -> out=0, out_valid=0, no change for several cycles.
- Nominal frame: release reset, then drive pairs (0x14,0x18),(0x28,0x18),(0x28,0x50),(0x20,0x20),(0x30,0x50),(0x20,0x30),(0x14,0x38),(0x38,0x50),(0x48,0x40),(0x20,0x30) on consecutive edges -> after the 10th edge out=0x0590 (89.0), out_valid pulses once.
- Zero frame: follow with 10 cycles of value=weight=0 -> out holds 0x0590 for 9 cycles, then becomes 0x0000 with an out_valid pulse.
- Negative/ReLU: ten pairs (0xFFF0 = −1.0, 0x0020 = 2.0) -> sum −20.0 -> out=0x0000.
- Saturation: ten pairs (0x7FFF, 0x7FFF) -> out=0x7FFF.
- Truncation plus mid-frame reset:
  - Pair (0x0001,0x0001) ×10 -> each product truncates to 0, so out=0x0000.
  - Then assert reset after 4 pairs of (0x10,0x10), release, and drive 10 pairs of (0x10,0x10) -> out=0x00A0 (10.0), with no leftover from the partial frame.

Source files
------------

// File: rtl/node_calc_pkg.sv
// Shared definitions for the neuron compute node: default widths,
// the Q12.4 sample type and the fixed-point reference constants.
package node_calc_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_FRAC_W   = 4;
  localparam int DEF_N_INPUTS = 10;
  localparam int DEF_ACC_W    = 32;

  typedef logic signed [15:0] q12_4_t;

  localparam q12_4_t Q_ONE = 16'sh0010;
  localparam q12_4_t Q_MAX = 16'sh7FFF;
  localparam q12_4_t Q_MIN = 16'sh8000;

endpackage

// File: rtl/node_mac.sv
// Combinational Q12.4 multiply: full-width product, rescaled by an
// arithmetic shift (floor), then sign-extended to the accumulator width.
module node_mac
  import node_calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [DATA_W-1:0] value,
  input  logic signed [DATA_W-1:0] weight,
  output logic signed [ACC_W-1:0]  prod_scaled
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_shift;

  // Multiply, drop the extra fractional bits toward -inf, resize to ACC_W.
  always_comb begin
    prod        = value * weight;
    prod_shift  = prod >>> FRAC_W;
    prod_scaled = ACC_W'(prod_shift);
  end

endmodule

// File: rtl/node_calculator.sv
// Single-neuron node: accumulates N_INPUTS scaled products per frame and
// registers relu(sat(sum)) on the edge that consumes the last pair.
module node_calculator
  import node_calc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] value,
  input  logic signed [DATA_W-1:0] weight,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  // Clamp the wide sum into the representable DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] s);
    if (s > SAT_HI)      return DATA_W'(SAT_HI);
    else if (s < SAT_LO) return DATA_W'(SAT_LO);
    else                 return DATA_W'(s);
  endfunction

  // Negative activations are forced to zero.
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  logic signed [ACC_W-1:0]  prod_scaled;
  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] res;
  logic [CNT_W-1:0]         cnt_p0;

  node_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .value       (value),
    .weight      (weight),
    .prod_scaled (prod_scaled)
  );

  // Running sum including the pair presented this cycle, and its output form.
  always_comb begin
    sum = acc_p0 + prod_scaled;
    res = relu(sat(sum));
  end

  // ---- stage p0: accumulate; at frame end load the result and restart ----
  // Frame sequencing: accumulate until the last pair, then publish and clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p0    <= '0;
      cnt_p0    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (cnt_p0 == LAST_IDX) begin
      out       <= res;
      out_valid <= 1'b1;
      acc_p0    <= '0;
      cnt_p0    <= '0;
    end else begin
      acc_p0    <= sum;
      cnt_p0    <= cnt_p0 + 1'b1;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_node_calculator.sv
// Self-checking bench for node_calculator with a frame-level integer model.
module tb_node_calculator;
  import node_calc_pkg::*;

  localparam int NI = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic signed [15:0] value;
  logic signed [15:0] weight;
  logic signed [15:0] out;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pair products summed as real-valued Q12.4 integers.
  longint m_sum;
  int     m_idx;
  logic [15:0] m_out;
  logic        m_valid;

  node_calculator #(
    .DATA_W   (16),
    .FRAC_W   (4),
    .N_INPUTS (NI),
    .ACC_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .weight    (weight),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic longint floor_div16(input longint p);
    if (p >= 0) return p / 16;
    return -((-p + 15) / 16);
  endfunction

  function automatic logic [15:0] node_result(input longint s);
    if (s > 32767) return 16'h7FFF;
    if (s < 0)     return 16'h0000;
    return 16'(s);
  endfunction

  task automatic model_clear();
    m_sum = 0; m_idx = 0; m_out = 16'h0000; m_valid = 1'b0;
  endtask

  // Present one pair, let the edge consume it, advance the model.
  task automatic step(input logic [15:0] v, input logic [15:0] w);
    value = v; weight = w;
    @(posedge clk); #1;
    if (!reset) begin
      model_clear();
    end else begin
      m_sum = m_sum + floor_div16(longint'($signed(v)) * longint'($signed(w)));
      m_idx = m_idx + 1;
      if (m_idx == NI) begin
        m_out = node_result(m_sum); m_valid = 1'b1; m_sum = 0; m_idx = 0;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; value = '0; weight = '0;
    model_clear();
    #2;
    for (int i = 0; i < 6; i++) begin
      step(16'($urandom), 16'($urandom));
      n_checks++;
      if (out !== 16'h0000 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: out=%h valid=%b required out=0000 valid=0", i, out, out_valid);
      end
    end
  endtask

  task automatic test_nominal();
    logic [15:0] vs [NI] = '{16'h14, 16'h28, 16'h28, 16'h20, 16'h30, 16'h20, 16'h14, 16'h38, 16'h48, 16'h20};
    logic [15:0] ws [NI] = '{16'h18, 16'h18, 16'h50, 16'h20, 16'h50, 16'h30, 16'h38, 16'h50, 16'h40, 16'h30};
    int pulses = 0;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      step(vs[i], ws[i]);
      if (out_valid === 1'b1) pulses++;
      if (i < NI - 1) begin
        n_checks++;
        if (out !== 16'h0000) begin
          n_fail++;
          $display("FAIL nominal_hold pair%0d: out=%h required 0000", i, out);
        end
      end
    end
    n_checks++;
    if (out !== 16'h0590 || out_valid !== 1'b1 || pulses != 1) begin
      n_fail++;
      $display("FAIL nominal_result: out=%h valid=%b pulses=%0d required out=0590 valid=1 pulses=1", out, out_valid, pulses);
    end
    n_checks++;
    if (out !== m_out) begin
      n_fail++;
      $display("FAIL nominal_model: out=%h model=%h", out, m_out);
    end
  endtask

  task automatic test_zero();
    for (int i = 0; i < NI; i++) begin
      step(16'h0, 16'h0);
      n_checks++;
      if (i < NI - 1) begin
        if (out !== 16'h0590 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL zero_hold pair%0d: out=%h valid=%b required out=0590 valid=0", i, out, out_valid);
        end
      end else if (out !== 16'h0000 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_result: out=%h valid=%b required out=0000 valid=1", out, out_valid);
      end
    end
  endtask

  task automatic test_frame(input string name, input logic [15:0] v, input logic [15:0] w,
                            input logic [15:0] expected);
    for (int i = 0; i < NI; i++) step(v, w);
    n_checks++;
    if (out !== expected || out_valid !== 1'b1 || out !== m_out) begin
      n_fail++;
      $display("FAIL %s: out=%h valid=%b model=%h required out=%h valid=1", name, out, out_valid, m_out, expected);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) step(Q_ONE, Q_ONE);
    reset = 1'b0;
    #1;
    n_checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: out=%h valid=%b required out=0000 valid=0", out, out_valid);
    end
    step(Q_ONE, Q_ONE);
    step(Q_ONE, Q_ONE);
    reset = 1'b1;
    test_frame("reset_discard", Q_ONE, Q_ONE, 16'h00A0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NI; i++) begin
        logic [15:0] v, w;
        if (f % 2 == 0) begin
          v = 16'($signed($urandom_range(0, 1023)) - 512);
          w = 16'($signed($urandom_range(0, 1023)) - 512);
        end else begin
          v = 16'($urandom); w = 16'($urandom);
        end
        step(v, w);
        n_checks++;
        if (out !== m_out || out_valid !== m_valid) begin
          n_fail++;
          $display("FAIL random f%0d p%0d: out=%h valid=%b required out=%h valid=%b", f, i, out, out_valid, m_out, m_valid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero();
    test_frame("relu_negative", 16'hFFF0, 16'h0020, 16'h0000);
    test_frame("saturation", Q_MAX, Q_MAX, 16'h7FFF);
    test_mid_reset();
    test_frame("truncation", 16'h0001, 16'h0001, 16'h0000);
    test_frame("sat_negative", Q_MIN, Q_MAX, 16'h0000);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
